// File: rtl/if_prefetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: memory fetch port, redirect
// inputs and the consumer valid/ready port. "master" is the prefetch queue
// side, "slave" is the environment (memory + decode) side.
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ack_i;
    logic [31:0]   mem_rdata_i;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   instr_pc_o;
    logic          instr_ready_i;
    logic [CW-1:0] count_o;

    modport master (
        input  redirect_i, redirect_pc_i, mem_ack_i, mem_rdata_i, instr_ready_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, mem_ack_i, mem_rdata_i, instr_ready_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one sequential word
// fetch at a time, buffers returned words in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes the queue and restarts fetching
// at the target; a response still in flight at that moment is discarded.
//
// Optional feature: define IF_PREFETCH_BYPASS_EN to forward an ack straight to
// the consumer outputs in the same cycle when the FIFO is empty.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    if_prefetch_queue_if.master bus_io
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [31:0]   memAddr_q, memAddr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]   dataMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];

    logic          fifoValid;
    logic          ackBusy;
    logic          bypassHit;
    logic          bypassTake;
    logic          popFifo;
    logic          pushFifo;
    logic          issue;
    logic [CW-1:0] countAfterPop;
    logic          unusedPcLsbs;

    // Target addresses are word aligned; the low two bits are dropped.
    assign unusedPcLsbs = ^bus_io.redirect_pc_i[1:0];

    // Decode this cycle's events; a redirect masks pops, pushes and new issues.
    always_comb begin
        fifoValid     = (count_q != '0);
        ackBusy       = (state_q == BUSY) && bus_io.mem_ack_i && !bus_io.redirect_i;
`ifdef IF_PREFETCH_BYPASS_EN
        bypassHit     = ackBusy && !fifoValid;
`else
        bypassHit     = 1'b0;
`endif
        bypassTake    = bypassHit && bus_io.instr_ready_i;
        popFifo       = fifoValid && bus_io.instr_ready_i && !bus_io.redirect_i;
        pushFifo      = ackBusy && !bypassTake;
        countAfterPop = count_q - CW'(popFifo);
        issue         = (state_q == IDLE) && !bus_io.redirect_i && (countAfterPop < DEPTH_C);
    end

    // State, fetch PC and FIFO bookkeeping registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            memAddr_q <= 32'd0;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            memAddr_q <= memAddr_d;
            count_q   <= count_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
        end
    end

    // FIFO storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (pushFifo) begin
            dataMem[wrPtr_q] <= bus_io.mem_rdata_i;
            pcMem[wrPtr_q]   <= memAddr_q;
        end
    end

    // Next fetch state: issue from IDLE, complete or discard on ack, redirect retargets.
    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        memAddr_d = memAddr_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = BUSY;
                    memAddr_d = fetchPc_q;
                end
            end
            BUSY: begin
                if (bus_io.mem_ack_i) begin
                    state_d = IDLE;
                end else if (bus_io.redirect_i) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus_io.mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ackBusy) begin
            fetchPc_d = fetchPc_q + 32'd4;
        end
        if (bus_io.redirect_i) begin
            fetchPc_d = {bus_io.redirect_pc_i[31:2], 2'b00};
        end
    end

    // FIFO pointers and occupancy; a flush empties the queue outright.
    always_comb begin
        if (bus_io.redirect_i) begin
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            count_d = count_q + CW'(pushFifo) - CW'(popFifo);
            rdPtr_d = rdPtr_q + PW'(popFifo);
            wrPtr_d = wrPtr_q + PW'(pushFifo);
        end
    end

    // Drive the bus: request from state, head entry (or forwarded ack word) to decode.
    always_comb begin
        bus_io.mem_req_o     = (state_q != IDLE);
        bus_io.mem_addr_o    = memAddr_q;
        bus_io.count_o       = count_q;
        bus_io.instr_valid_o = fifoValid || bypassHit;
        bus_io.instr_o       = 32'd0;
        bus_io.instr_pc_o    = 32'd0;
        if (fifoValid) begin
            bus_io.instr_o    = dataMem[rdPtr_q];
            bus_io.instr_pc_o = pcMem[rdPtr_q];
        end else if (bypassHit) begin
            bus_io.instr_o    = bus_io.mem_rdata_i;
            bus_io.instr_pc_o = memAddr_q;
        end
    end
endmodule
